// File: rtl/bus85_if.sv
// core85 multiplexed system bus as seen by a memory-side responder.
interface bus85_if #(
   parameter int ADDRSIZE = 16,
   parameter int DATASIZE = 8
);
   logic [DATASIZE-1:0]          ad_in;
   logic [ADDRSIZE-DATASIZE-1:0] addr;
   logic                         ale;
   logic                         iom_;
   logic                         rd_;
   logic                         wr_;
   logic [DATASIZE-1:0]          ad_out;
   logic                         ad_oe;
   logic                         ready;
   logic                         hit;

   modport master (
      output ad_in, addr, ale, iom_, rd_, wr_,
      input  ad_out, ad_oe, ready, hit
   );

   modport slave (
      input  ad_in, addr, ale, iom_, rd_, wr_,
      output ad_out, ad_oe, ready, hit
   );
endinterface

// File: rtl/bus85_mem.sv
// Memory responder for the core85 bus: ALE demux, window decode,
// byte RAM with programmable READY wait states.
module bus85_mem #(
   parameter int                  ADDRSIZE = 16,
   parameter int                  DATASIZE = 8,
   parameter int                  MEMBITS  = 10,
   parameter logic [ADDRSIZE-1:0] BASEADDR = '0,
   parameter int                  WAITS    = 1
) (
   input logic    clk,
   input logic    rst,
   bus85_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_READ,
      S_WRITE
   } state_t;

   localparam logic [3:0] NWAIT = 4'(WAITS);

   logic [DATASIZE-1:0] ram [2**MEMBITS];

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                isrd_q, isrd_d;
   logic [MEMBITS-1:0]  idx_q;
   logic                hit_q;
   logic [DATASIZE-1:0] wdata_q;
   logic [DATASIZE-1:0] ad_out_q, ad_out_d;
   logic                ad_oe_q, ad_oe_d;
   logic                ready_q, ready_d;
   logic                we;
   logic                rd_req, wr_req;
   logic [ADDRSIZE-1:0] lat;

   assign lat    = {bus.addr, bus.ad_in};
   assign rd_req = ~bus.rd_ & bus.wr_;
   assign wr_req = bus.rd_ & ~bus.wr_;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      isrd_d   = isrd_q;
      ad_out_d = ad_out_q;
      ad_oe_d  = ad_oe_q;
      ready_d  = 1'b1;
      we       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ad_oe_d = 1'b0;
            if (!bus.ale && hit_q && (rd_req || wr_req)) begin
               state_d = S_WAIT;
               cnt_d   = NWAIT;
               isrd_d  = rd_req;
               ready_d = (NWAIT == 4'd0);
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d   = cnt_q - 4'd1;
               ready_d = (cnt_q == 4'd1);
            end else if (isrd_q) begin
               state_d  = S_READ;
               ad_out_d = ram[idx_q];
               ad_oe_d  = 1'b1;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_READ: begin
            if (bus.rd_) begin
               state_d = S_IDLE;
               ad_oe_d = 1'b0;
            end
         end
         S_WRITE: begin
            if (bus.wr_) begin
               state_d = S_IDLE;
               we      = 1'b1;
            end
         end
      endcase
      // a new address phase always wins over an access in flight
      if (bus.ale && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         ad_oe_d = 1'b0;
         ready_d = 1'b1;
         we      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         isrd_q   <= 1'b0;
         idx_q    <= '0;
         hit_q    <= 1'b0;
         wdata_q  <= '0;
         ad_out_q <= '0;
         ad_oe_q  <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         isrd_q   <= isrd_d;
         ad_out_q <= ad_out_d;
         ad_oe_q  <= ad_oe_d;
         ready_q  <= ready_d;
         if (bus.ale) begin
            idx_q <= lat[MEMBITS-1:0];
            hit_q <= ~bus.iom_ &&
                     (lat[ADDRSIZE-1:MEMBITS] ==
                      BASEADDR[ADDRSIZE-1:MEMBITS]);
         end
         if (!bus.wr_) begin
            wdata_q <= bus.ad_in;
         end
      end
   end

   // RAM is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         ram[idx_q] <= wdata_q;
      end
   end

   assign bus.ad_out = ad_out_q;
   assign bus.ad_oe  = ad_oe_q;
   assign bus.ready  = ready_q;
   assign bus.hit    = hit_q;

endmodule

// File: tb/tb_bus85_mem.sv
// Drives three responders (WAITS 0/1/3) with one shared bus and
// checks them against a byte-array memory model.
module tb_bus85_mem;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ad_in, addr;
   logic       ale, iom_, rd_, wr_;

   logic       rdy [3];
   logic       oe  [3];
   logic       hto [3];
   logic [7:0] dout[3];

   int total = 0;
   int bad   = 0;
   int WS[3] = '{0, 1, 3};

   logic [7:0] mem_m[1024];
   bit         val_m[1024];

   always #5 clk = ~clk;

   bus85_if bi[3] ();

   for (genvar i = 0; i < 3; i++) begin : g_dut
      assign bi[i].ad_in = ad_in;
      assign bi[i].addr  = addr;
      assign bi[i].ale   = ale;
      assign bi[i].iom_  = iom_;
      assign bi[i].rd_   = rd_;
      assign bi[i].wr_   = wr_;
      assign rdy[i]  = bi[i].ready;
      assign oe[i]   = bi[i].ad_oe;
      assign hto[i]  = bi[i].hit;
      assign dout[i] = bi[i].ad_out;
      bus85_mem #(
         .ADDRSIZE(16),
         .DATASIZE(8),
         .MEMBITS (10),
         .BASEADDR(16'h0000),
         .WAITS   (i == 0 ? 0 : (i == 1 ? 1 : 3))
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bi[i])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      ale = 1'b0; rd_ = 1'b1; wr_ = 1'b1; iom_ = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_ready"}, 32'(rdy[i]), 32'd1);
         chk({tag, "_oe"}, 32'(oe[i]), 32'd0);
      end
   endtask

   // kind: 0 read, 1 write, 2 INTA (no strobe), 3 both strobes low
   task automatic cycle(input logic [15:0] a, input bit io,
                        input int kind, input logic [7:0] d);
      bit         h, act;
      int         lowc [3];
      int         first[3];
      logic [7:0] got  [3];
      h   = !io && (a < 16'h0400);
      act = h && (kind < 2);
      ale = 1'b1; addr = a[15:8]; ad_in = a[7:0];
      iom_ = io; rd_ = 1'b1; wr_ = 1'b1;
      step();
      for (int i = 0; i < 3; i++) chk("hit", 32'(hto[i]), 32'(h));
      ale = 1'b0;
      case (kind)
         0: rd_ = 1'b0;
         1: begin wr_ = 1'b0; ad_in = d; end
         3: begin rd_ = 1'b0; wr_ = 1'b0; ad_in = d; end
         default: ;
      endcase
      for (int i = 0; i < 3; i++) begin
         lowc[i] = 0; first[i] = -1; got[i] = '0;
      end
      for (int k = 0; k < 8; k++) begin
         step();
         for (int i = 0; i < 3; i++) begin
            if (!rdy[i]) lowc[i]++;
            if (oe[i] && first[i] < 0) begin
               first[i] = k;
               got[i]   = dout[i];
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         chk("ready_low_cycles", 32'(lowc[i]), act ? 32'(WS[i]) : 32'd0);
         chk("data_edge", 32'(first[i]),
             (act && kind == 0) ? 32'(WS[i] + 1) : 32'hFFFF_FFFF);
         chk("oe_hold", 32'(oe[i]), 32'(act && kind == 0));
         if (act && kind == 0 && val_m[a[9:0]])
            chk("rdata", 32'(got[i]), 32'(mem_m[a[9:0]]));
      end
      rd_ = 1'b1; wr_ = 1'b1;
      step();
      for (int i = 0; i < 3; i++) chk("oe_release", 32'(oe[i]), 32'd0);
      if (act && kind == 1) begin
         mem_m[a[9:0]] = d;
         val_m[a[9:0]] = 1'b1;
      end
      step();
   endtask

   initial begin
      logic [15:0] ra;
      for (int j = 0; j < 1024; j++) val_m[j] = 1'b0;
      rst = 1'b1; ad_in = '0; addr = '0;
      idle_bus();

      for (int c = 0; c < 3; c++) begin
         ale = 1'($urandom); iom_ = 1'($urandom);
         rd_ = 1'($urandom); wr_ = 1'($urandom);
         ad_in = 8'($urandom); addr = 8'($urandom);
         step();
         for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 32'(rdy[i]), 32'd1);
            chk("rst_oe", 32'(oe[i]), 32'd0);
            chk("rst_dout", 32'(dout[i]), 32'd0);
            chk("rst_hit", 32'(hto[i]), 32'd0);
         end
      end
      rst = 1'b0;
      idle_bus();
      step();
      chk_quiet("post_rst");

      cycle(16'h0012, 1'b0, 1, 8'hA5);
      cycle(16'h0012, 1'b0, 0, 8'h00);
      cycle(16'h03FF, 1'b0, 1, 8'h3C);
      cycle(16'h03FF, 1'b0, 0, 8'h00);

      cycle(16'h0012, 1'b1, 0, 8'h00);
      cycle(16'h0400, 1'b0, 0, 8'h00);
      cycle(16'h0012, 1'b0, 2, 8'h00);

      cycle(16'h0020, 1'b0, 1, 8'h11);
      ale = 1'b1; addr = 8'h00; ad_in = 8'h20;
      step();
      ale = 1'b0; wr_ = 1'b0; ad_in = 8'h99;
      step();
      ale = 1'b1; ad_in = 8'h30; wr_ = 1'b1;
      step();
      chk_quiet("abort");
      ale = 1'b0;
      step();
      step();
      chk_quiet("abort_idle");
      cycle(16'h0020, 1'b0, 0, 8'h00);

      ale = 1'b1; addr = 8'h00; ad_in = 8'h12;
      step();
      ale = 1'b0; rd_ = 1'b0;
      for (int k = 0; k < 6; k++) step();
      for (int i = 0; i < 3; i++) chk("pre_rst_oe", 32'(oe[i]), 32'd1);
      rst = 1'b1;
      step();
      chk_quiet("rst_read");
      rst = 1'b0; rd_ = 1'b1;
      step();
      chk_quiet("rst_read_after");

      cycle(16'h0005, 1'b0, 1, 8'h77);
      cycle(16'h0005, 1'b0, 3, 8'hEE);
      cycle(16'h0005, 1'b0, 0, 8'h00);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0)
            ra = 16'($urandom_range(16'h0400, 16'hFFFF));
         else
            ra = 16'($urandom_range(0, 1023));
         cycle(ra, $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 3)), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
